// File: rtl/sram_word_ctrl.sv
// sram_word_ctrl: turns one 32-bit MEM-stage load/store into two 16-bit
// accesses (low halfword, then high halfword) on an asynchronous SRAM.
// Each half is held on the pins for ACCESS_CYCLES clocks, and pause
// freezes the pipeline until the access completes.
// Optional macro SRAM_WORD_CTRL_LAST_READ_EN adds a one-entry cache of the
// last completed read, so a repeated read of the same word skips the SRAM.
module sram_word_ctrl #(
    parameter int ACCESS_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        pause,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [3:0] LAST_PHASE = 4'(ACCESS_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_phase;
    logic        r_is_wr;
    logic [16:0] r_word;
    logic [31:0] r_wdata;
    logic [15:0] r_lo;
    logic [31:0] r_rdata;
    logic [17:0] r_addr;
    logic        r_we_n;
    logic        r_oe_n;
    logic        r_drive;
    logic [15:0] r_dq;

    logic        w_req;
    logic        w_hit;
    logic        w_start;
    logic        w_last;
    logic [16:0] w_word;
    logic        w_unused_addr;

    assign w_req   = wr_en | rd_en;
    assign w_word  = address[18:2];
    assign w_last  = (r_phase == LAST_PHASE);
    assign w_start = (r_state == IDLE) & w_req & ~w_hit;

    // Byte lanes and chip enable are always active; only whole words move.
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_ADDR = r_addr;
    assign SRAM_WE_N = r_we_n;
    assign SRAM_OE_N = r_oe_n;
    assign SRAM_DQ   = r_drive ? r_dq : 16'hzzzz;
    assign read_data = r_rdata;

    // Address bits outside the word index carry no meaning here.
    assign w_unused_addr = ^{address[31:19], address[1:0]};

    // Freeze the pipeline from the request cycle through the last half-access;
    // DONE drops it so the MEM stage can retire the instruction.
    always_comb begin
        pause = 1'b0;
        case (r_state)
            IDLE:    pause = w_req & ~w_hit;
            LOW:     pause = 1'b1;
            HIGH:    pause = 1'b1;
            default: pause = 1'b0;
        endcase
    end

`ifdef SRAM_WORD_CTRL_LAST_READ_EN
    logic        r_c_vld;
    logic [16:0] r_c_word;
    logic [31:0] r_c_data;

    // A plain read (no write alongside) of the cached word is served locally.
    assign w_hit = rd_en & ~wr_en & r_c_vld & (r_c_word == w_word);

    // Remember the last completed read; keep it coherent with later writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_c_vld  <= 1'b0;
            r_c_word <= '0;
            r_c_data <= '0;
        end else if (r_state == HIGH && w_last) begin
            if (!r_is_wr) begin
                r_c_vld  <= 1'b1;
                r_c_word <= r_word;
                r_c_data <= {SRAM_DQ, r_lo};
            end else if (r_c_vld && r_c_word == r_word) begin
                r_c_data <= r_wdata;
            end
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    // Access sequencer: all pin-facing outputs are registered so they change
    // together on the edge that enters or leaves a half-access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_phase <= '0;
            r_is_wr <= 1'b0;
            r_word  <= '0;
            r_wdata <= '0;
            r_lo    <= '0;
            r_rdata <= '0;
            r_addr  <= '0;
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_drive <= 1'b0;
            r_dq    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        // Write wins when both requests are raised together.
                        r_state <= LOW;
                        r_phase <= '0;
                        r_is_wr <= wr_en;
                        r_word  <= w_word;
                        r_wdata <= write_data;
                        r_addr  <= {w_word, 1'b0};
                        r_we_n  <= ~wr_en;
                        r_oe_n  <= wr_en;
                        r_drive <= wr_en;
                        r_dq    <= write_data[15:0];
                    end
`ifdef SRAM_WORD_CTRL_LAST_READ_EN
                    else if (w_hit) begin
                        r_rdata <= r_c_data;
                    end
`endif
                end
                LOW: begin
                    if (w_last) begin
                        r_state <= HIGH;
                        r_phase <= '0;
                        r_addr  <= {r_word, 1'b1};
                        r_dq    <= r_wdata[31:16];
                        if (!r_is_wr) r_lo <= SRAM_DQ;
                    end else begin
                        r_phase <= r_phase + 4'd1;
                    end
                end
                HIGH: begin
                    if (w_last) begin
                        // read_data changes only once the whole word is in.
                        r_state <= DONE;
                        r_phase <= '0;
                        r_we_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_drive <= 1'b0;
                        if (!r_is_wr) r_rdata <= {SRAM_DQ, r_lo};
                    end else begin
                        r_phase <= r_phase + 4'd1;
                    end
                end
                default: begin
                    // Requests still held here belong to the finished access.
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_word_ctrl.sv
// tb_sram_word_ctrl: two controllers (ACCESS_CYCLES 1 and 3), each on its own
// behavioural SRAM, checked against a word-level memory/cache model.
module tb_sram_word_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic        probe_a = 1'b0;

    logic [31:0] rdata_a, rdata_b;
    logic        pause_a, pause_b;
    wire  [15:0] dq_a, dq_b;
    logic [17:0] addr_a, addr_b;
    logic        ub_a, lb_a, we_a, ce_a, oe_a;
    logic        ub_b, lb_b, we_b, ce_b, oe_b;

    logic [15:0] mem_a [0:262143];
    logic [15:0] mem_b [0:262143];

    int checks = 0;
    int errors = 0;
    int ac [2] = '{1, 3};

    always #5 clk = ~clk;

    sram_word_ctrl #(.ACCESS_CYCLES(1)) u_dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en & ~sel), .rd_en(rd_en & ~sel),
        .address(address), .write_data(write_data), .read_data(rdata_a),
        .pause(pause_a), .SRAM_DQ(dq_a), .SRAM_ADDR(addr_a), .SRAM_UB_N(ub_a),
        .SRAM_LB_N(lb_a), .SRAM_WE_N(we_a), .SRAM_CE_N(ce_a), .SRAM_OE_N(oe_a)
    );

    sram_word_ctrl #(.ACCESS_CYCLES(3)) u_dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en & sel), .rd_en(rd_en & sel),
        .address(address), .write_data(write_data), .read_data(rdata_b),
        .pause(pause_b), .SRAM_DQ(dq_b), .SRAM_ADDR(addr_b), .SRAM_UB_N(ub_b),
        .SRAM_LB_N(lb_b), .SRAM_WE_N(we_b), .SRAM_CE_N(ce_b), .SRAM_OE_N(oe_b)
    );

    // Behavioural asynchronous SRAMs; probe_a parks bus A at zero when idle.
    assign dq_a = (!oe_a && we_a) ? mem_a[addr_a] : (probe_a ? 16'h0000 : 16'hzzzz);
    assign dq_b = (!oe_b && we_b) ? mem_b[addr_b] : 16'hzzzz;

    always @(posedge clk) begin
        if (!we_a) mem_a[addr_a] <= dq_a;
        if (!we_b) mem_b[addr_b] <= dq_b;
    end

    logic        o_pause, o_we, o_oe;
    logic [31:0] o_rdata;
    logic [17:0] o_addr;
    logic [15:0] o_dq;
    assign o_pause = sel ? pause_b : pause_a;
    assign o_rdata = sel ? rdata_b : rdata_a;
    assign o_addr  = sel ? addr_b  : addr_a;
    assign o_we    = sel ? we_b    : we_a;
    assign o_oe    = sel ? oe_b    : oe_a;
    assign o_dq    = sel ? dq_b    : dq_a;

    // Word-level reference: memory contents, last read value, last-read cache.
    logic [31:0] ref_mem [int];
    logic [31:0] exp_rdata [2];
    bit          cval [2];
    int          cword [2];
    logic [31:0] cdata [2];

    function automatic logic [31:0] ref_rd(input bit s, input int word);
        int key = s * 262144 + word;
        return ref_mem.exists(key) ? ref_mem[key] : 32'h0;
    endfunction

    function automatic bit model_hit(input bit s, input bit w, input bit r, input logic [31:0] a);
`ifdef SRAM_WORD_CTRL_LAST_READ_EN
        return r && !w && cval[s] && cword[s] == int'(a[18:2]);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_apply(input bit s, input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
        int word = int'(a[18:2]);
        if (w) begin
            ref_mem[s * 262144 + word] = d;
            if (cval[s] && cword[s] == word) cdata[s] = d;
        end else if (r) begin
            exp_rdata[s] = ref_rd(s, word);
            cval[s]  = 1'b1;
            cword[s] = word;
            cdata[s] = exp_rdata[s];
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            exp_rdata[i] = '0;
            cval[i] = 1'b0;
        end
    endtask

    // Per-cycle trace of one access: index 0 is the request cycle.
    int          npause;
    bit          saw_oe_low;
    logic [17:0] tr_addr [$];
    logic        tr_we [$];
    logic        tr_oe [$];
    logic [15:0] tr_dq [$];

    task automatic do_access(input bit s, input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = s; wr_en = w; rd_en = r; address = a; write_data = d;
        #1;
        npause = 0; saw_oe_low = 1'b0;
        tr_addr.delete(); tr_we.delete(); tr_oe.delete(); tr_dq.delete();
        while (o_pause && npause < 64) begin
            tr_addr.push_back(o_addr); tr_we.push_back(o_we);
            tr_oe.push_back(o_oe); tr_dq.push_back(o_dq);
            if (!o_oe) saw_oe_low = 1'b1;
            npause++;
            @(negedge clk); #1;
        end
        if (!o_oe) saw_oe_low = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        wr_en = 1'b0; rd_en = 1'b0; probe_a = 1'b1; sel = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (o_pause !== 1'b0) begin errors++; $display("FAIL reset_pause got %b want 0", o_pause); end
        checks++; if (rdata_a !== 32'h0 || rdata_b !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h/%h want 0", rdata_a, rdata_b); end
        checks++; if ({we_a, oe_a, we_b, oe_b} !== 4'b1111) begin errors++; $display("FAIL reset_strobes got %b want 1111", {we_a, oe_a, we_b, oe_b}); end
        checks++; if (addr_a !== 18'h0 || addr_b !== 18'h0) begin errors++; $display("FAIL reset_addr got %h/%h want 0", addr_a, addr_b); end
        checks++; if (dq_a !== 16'h0) begin errors++; $display("FAIL reset_dq_released got %h want 0000", dq_a); end
        checks++; if ({ub_a, lb_a, ce_a, ub_b, lb_b, ce_b} !== 6'b0) begin errors++; $display("FAIL tieoffs got %b want 000000", {ub_a, lb_a, ce_a, ub_b, lb_b, ce_b}); end
        wr_en = 1'b1; #1;
        checks++; if (o_pause !== 1'b1) begin errors++; $display("FAIL reset_pause_req got %b want 1", o_pause); end
        wr_en = 1'b0;
        @(negedge clk); rst = 1'b1; probe_a = 1'b0;
        model_reset();
    endtask

    task automatic test_write_basic();
        do_access(0, 1, 0, 32'h0000_0004, 32'hDEAD_BEEF);
        model_apply(0, 1, 0, 32'h0000_0004, 32'hDEAD_BEEF);
        checks++; if (npause !== 3) begin errors++; $display("FAIL wr_pause_len got %0d want 3", npause); end
        if (npause == 3) begin
            checks++; if (tr_addr[1] !== 18'h00002 || tr_dq[1] !== 16'hBEEF || tr_we[1] !== 1'b0 || tr_oe[1] !== 1'b1)
                begin errors++; $display("FAIL wr_low got a=%h dq=%h we=%b oe=%b want 00002 BEEF 0 1", tr_addr[1], tr_dq[1], tr_we[1], tr_oe[1]); end
            checks++; if (tr_addr[2] !== 18'h00003 || tr_dq[2] !== 16'hDEAD || tr_we[2] !== 1'b0 || tr_oe[2] !== 1'b1)
                begin errors++; $display("FAIL wr_high got a=%h dq=%h we=%b oe=%b want 00003 DEAD 0 1", tr_addr[2], tr_dq[2], tr_we[2], tr_oe[2]); end
        end
        checks++; if (o_we !== 1'b1 || o_pause !== 1'b0 || o_addr !== 18'h00003) begin errors++; $display("FAIL wr_after got we=%b pause=%b a=%h want 1 0 00003", o_we, o_pause, o_addr); end
        checks++; if ({mem_a[2], mem_a[3]} !== {16'hBEEF, 16'hDEAD}) begin errors++; $display("FAIL wr_sram got %h %h want BEEF DEAD", mem_a[2], mem_a[3]); end
    endtask

    task automatic test_read_basic();
        do_access(0, 0, 1, 32'h0000_0004, 32'h0);
        model_apply(0, 0, 1, 32'h0000_0004, 32'h0);
        checks++; if (npause !== 3) begin errors++; $display("FAIL rd_pause_len got %0d want 3", npause); end
        if (npause == 3) begin
            checks++; if (tr_oe[1] !== 1'b0 || tr_oe[2] !== 1'b0 || tr_we[1] !== 1'b1 || tr_we[2] !== 1'b1)
                begin errors++; $display("FAIL rd_strobes got oe=%b%b we=%b%b want 00 11", tr_oe[1], tr_oe[2], tr_we[1], tr_we[2]); end
            checks++; if (tr_dq[1] !== 16'hBEEF || tr_dq[2] !== 16'hDEAD) begin errors++; $display("FAIL rd_bus got %h %h want BEEF DEAD", tr_dq[1], tr_dq[2]); end
        end
        checks++; if (o_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data got %h want DEADBEEF", o_rdata); end
    endtask

    task automatic test_ac3_top_word();
        logic [31:0] d = $urandom;
        do_access(1, 1, 0, 32'hABC7_FFFF, d);
        model_apply(1, 1, 0, 32'hABC7_FFFF, d);
        do_access(1, 0, 1, 32'h0007_FFFC, 32'h0);
        model_apply(1, 0, 1, 32'h0007_FFFC, 32'h0);
        checks++; if (npause !== 7) begin errors++; $display("FAIL ac3_pause_len got %0d want 7", npause); end
        if (npause == 7) begin
            for (int i = 1; i <= 6; i++) begin
                checks++; if (tr_addr[i] !== ((i <= 3) ? 18'h3FFFE : 18'h3FFFF) || tr_oe[i] !== 1'b0)
                    begin errors++; $display("FAIL ac3_cycle%0d got a=%h oe=%b want %h 0", i, tr_addr[i], tr_oe[i], (i <= 3) ? 18'h3FFFE : 18'h3FFFF); end
            end
        end
        checks++; if (o_rdata !== d) begin errors++; $display("FAIL ac3_data got %h want %h", o_rdata, d); end
    endtask

    task automatic test_both_requests();
        logic [31:0] prev = exp_rdata[0];
        do_access(0, 1, 1, 32'h0000_0010, 32'h1234_5678);
        model_apply(0, 1, 1, 32'h0000_0010, 32'h1234_5678);
        checks++; if (npause !== 3) begin errors++; $display("FAIL both_pause_len got %0d want 3", npause); end
        if (npause == 3) begin
            checks++; if (tr_we[1] !== 1'b0 || tr_we[2] !== 1'b0) begin errors++; $display("FAIL both_is_write got we=%b%b want 00", tr_we[1], tr_we[2]); end
        end
        checks++; if (o_rdata !== prev) begin errors++; $display("FAIL both_rdata_kept got %h want %h", o_rdata, prev); end
        do_access(0, 0, 1, 32'h0000_0010, 32'h0);
        model_apply(0, 0, 1, 32'h0000_0010, 32'h0);
        checks++; if (o_rdata !== 32'h1234_5678) begin errors++; $display("FAIL both_readback got %h want 12345678", o_rdata); end
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        sel = 1'b0; wr_en = 1'b1; address = 32'h0000_0400; write_data = 32'hDEAD_BEEF;
        @(negedge clk); @(negedge clk); #1;
        checks++; if (o_we !== 1'b0 || o_addr !== 18'h00201 || o_dq !== 16'hDEAD) begin errors++; $display("FAIL mid_in_high got we=%b a=%h dq=%h want 0 00201 DEAD", o_we, o_addr, o_dq); end
        probe_a = 1'b1; rst = 1'b0; #1;
        model_reset();
        checks++; if (o_we !== 1'b1 || o_oe !== 1'b1 || o_dq !== 16'h0000) begin errors++; $display("FAIL mid_release got we=%b oe=%b dq=%h want 1 1 0000", o_we, o_oe, o_dq); end
        checks++; if (rdata_a !== 32'h0 || rdata_b !== 32'h0 || o_addr !== 18'h0) begin errors++; $display("FAIL mid_regs got %h/%h a=%h want 0", rdata_a, rdata_b, o_addr); end
        checks++; if (o_pause !== 1'b1) begin errors++; $display("FAIL mid_pause_idle got %b want 1", o_pause); end
        wr_en = 1'b0;
        @(negedge clk); rst = 1'b1; probe_a = 1'b0;
        do_access(0, 0, 1, 32'h0000_0004, 32'h0);
        model_apply(0, 0, 1, 32'h0000_0004, 32'h0);
        checks++; if (npause !== 3) begin errors++; $display("FAIL mid_after_len got %0d want 3", npause); end
        checks++; if (o_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mid_after_data got %h want DEADBEEF", o_rdata); end
    endtask

`ifdef SRAM_WORD_CTRL_LAST_READ_EN
    task automatic test_last_read_cache();
        do_access(0, 0, 1, 32'h0000_0008, 32'h0);
        model_apply(0, 0, 1, 32'h0000_0008, 32'h0);
        checks++; if (npause !== 3) begin errors++; $display("FAIL cache_miss_len got %0d want 3", npause); end
        do_access(0, 0, 1, 32'h0000_0008, 32'h0);
        model_apply(0, 0, 1, 32'h0000_0008, 32'h0);
        checks++; if (npause !== 0 || saw_oe_low) begin errors++; $display("FAIL cache_hit got pause=%0d oe_low=%b want 0 0", npause, saw_oe_low); end
        checks++; if (o_rdata !== exp_rdata[0]) begin errors++; $display("FAIL cache_hit_data got %h want %h", o_rdata, exp_rdata[0]); end
        do_access(0, 1, 0, 32'h0000_0008, 32'hA5A5_A5A5);
        model_apply(0, 1, 0, 32'h0000_0008, 32'hA5A5_A5A5);
        do_access(0, 0, 1, 32'h0000_0008, 32'h0);
        model_apply(0, 0, 1, 32'h0000_0008, 32'h0);
        checks++; if (npause !== 0 || o_rdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL cache_wr_update got pause=%0d data=%h want 0 A5A5A5A5", npause, o_rdata); end
    endtask
`endif

    task automatic test_random();
        int pool [8] = '{0, 1, 2, 3, 4, 5, 'h1FFFE, 'h1FFFF};
        for (int n = 0; n < 60; n++) begin
            bit s = 1'($urandom_range(0, 1));
            int k = $urandom_range(0, 3);
            bit w = (k == 0 || k == 3);
            bit r = (k != 0);
            logic [31:0] a = $urandom;
            logic [31:0] d = $urandom;
            bit hit;
            int exp_n;
            a[18:2] = 17'(pool[$urandom_range(0, 7)]);
            hit = model_hit(s, w, r, a);
            exp_n = hit ? 0 : 2 * ac[s] + 1;
            do_access(s, w, r, a, d);
            model_apply(s, w, r, a, d);
            checks++; if (npause !== exp_n) begin errors++; $display("FAIL rnd%0d_len got %0d want %0d", n, npause, exp_n); end
            if (npause == exp_n && !hit) begin
                for (int i = 1; i <= 2 * ac[s]; i++) begin
                    bit hi = (i > ac[s]);
                    logic [17:0] ea = {a[18:2], hi};
                    checks++;
                    if (tr_addr[i] !== ea || tr_we[i] !== !w || tr_oe[i] !== w ||
                        (w && tr_dq[i] !== (hi ? d[31:16] : d[15:0]))) begin
                        errors++;
                        $display("FAIL rnd%0d_cyc%0d got a=%h we=%b oe=%b dq=%h want a=%h we=%b oe=%b dq=%h",
                                 n, i, tr_addr[i], tr_we[i], tr_oe[i], tr_dq[i], ea, !w, w, hi ? d[31:16] : d[15:0]);
                    end
                end
            end
            checks++; if (o_rdata !== exp_rdata[s]) begin errors++; $display("FAIL rnd%0d_rdata got %h want %h", n, o_rdata, exp_rdata[s]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 262144; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        model_reset();
        test_reset();
        test_write_basic();
        test_read_basic();
        test_ac3_top_word();
        test_both_requests();
        test_reset_mid_write();
`ifdef SRAM_WORD_CTRL_LAST_READ_EN
        test_last_read_cache();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
